// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Merges two writeback requesters onto the single register-file write port.
//   A = ALU result, B = memory/load result. Each side has a one-entry holding
//   buffer. A combinational grant picks one full buffer per cycle, and the
//   write port is registered from the granted entry.
//
// Ports
//   clk, rst_n                : clock (rising edge), async active-low reset
//   a_valid/a_addr/a_data     : requester A write request
//   a_ready                   : A accepted when a_valid & a_ready
//   b_valid/b_addr/b_data     : requester B write request
//   b_ready                   : B accepted when b_valid & b_ready
//   sel                       : registered address-mux select, 1 = A, 0 = B
//   we/waddr/wdata            : registered register-file write port
//   conflicts                 : saturating count of cycles with both buffers full
module wb_port_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          sel,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic [CW-1:0] conflicts
);

    // Holding buffers
    logic          full_a_q, full_a_d;
    logic [AW-1:0] addr_a_q, addr_a_d;
    logic [DW-1:0] data_a_q, data_a_d;
    logic          full_b_q, full_b_d;
    logic [AW-1:0] addr_b_q, addr_b_d;
    logic [DW-1:0] data_b_q, data_b_d;

    // Last-grant pointer: 1 = A was granted last, 0 = B
    logic          lg_a_q, lg_a_d;

    // Write port and statistics
    logic          sel_q, sel_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] conflicts_q, conflicts_d;

    logic both_full;
    logic same_addr;
    logic grant_a;
    logic grant_b;
    logic acc_a;
    logic acc_b;

    assign both_full = full_a_q & full_b_q;
    assign same_addr = (addr_a_q == addr_b_q);

    // Equal destinations always go to B first: the load is older in program
    // order, so A's value must land last. Otherwise round-robin against lg.
    assign grant_a = full_a_q & (~full_b_q | (~same_addr & ~lg_a_q));
    assign grant_b = full_b_q & (~full_a_q | same_addr | lg_a_q);

    // A buffer being drained this cycle can take a new entry at the same edge.
    assign a_ready = ~full_a_q | grant_a;
    assign b_ready = ~full_b_q | grant_b;

    assign acc_a = a_valid & a_ready;
    assign acc_b = b_valid & b_ready;

    always_comb begin
        full_a_d    = full_a_q;
        addr_a_d    = addr_a_q;
        data_a_d    = data_a_q;
        full_b_d    = full_b_q;
        addr_b_d    = addr_b_q;
        data_b_d    = data_b_q;
        lg_a_d      = lg_a_q;
        sel_d       = sel_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        conflicts_d = conflicts_q;

        // Unload on grant, then a same-cycle accept overrides with the reload.
        if (grant_a) full_a_d = 1'b0;
        if (grant_b) full_b_d = 1'b0;
        if (acc_a) begin
            full_a_d = 1'b1;
            addr_a_d = a_addr;
            data_a_d = a_data;
        end
        if (acc_b) begin
            full_b_d = 1'b1;
            addr_b_d = b_addr;
            data_b_d = b_data;
        end

        // Register zero is consumed and steers the port, but never written.
        if (grant_a) begin
            lg_a_d  = 1'b1;
            sel_d   = 1'b1;
            we_d    = (addr_a_q != '0);
            waddr_d = addr_a_q;
            wdata_d = data_a_q;
        end else if (grant_b) begin
            lg_a_d  = 1'b0;
            sel_d   = 1'b0;
            we_d    = (addr_b_q != '0);
            waddr_d = addr_b_q;
            wdata_d = data_b_q;
        end

        if (both_full && (conflicts_q != {CW{1'b1}}))
            conflicts_d = conflicts_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_a_q    <= 1'b0;
            addr_a_q    <= '0;
            data_a_q    <= '0;
            full_b_q    <= 1'b0;
            addr_b_q    <= '0;
            data_b_q    <= '0;
            lg_a_q      <= 1'b0;
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            conflicts_q <= '0;
        end else begin
            full_a_q    <= full_a_d;
            addr_a_q    <= addr_a_d;
            data_a_q    <= data_a_d;
            full_b_q    <= full_b_d;
            addr_b_q    <= addr_b_d;
            data_b_q    <= data_b_d;
            lg_a_q      <= lg_a_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            conflicts_q <= conflicts_d;
        end
    end

    assign sel       = sel_q;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign conflicts = conflicts_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter. The reference model keeps each holding
// buffer as a queue of pending writes and applies the arbitration rules
// directly. CW is reduced so the saturating counter can be reached quickly.
module tb_wb_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready;
    logic          sel, we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [CW-1:0] conflicts;

    wb_port_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .sel(sel), .we(we), .waddr(waddr), .wdata(wdata), .conflicts(conflicts)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Register file as seen through the DUT write port
    logic [DW-1:0] dut_rf [32];
    always @(negedge clk) if (we) dut_rf[waddr] = wdata;

    // Reference model state
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;
    ent_t          qa[$];
    ent_t          qb[$];
    bit            m_lg_a;
    logic          m_we, m_sel;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_conf;

    function automatic void model_grant(output bit ga, output bit gb);
        ga = 0;
        gb = 0;
        if (qa.size() != 0 && qb.size() != 0) begin
            if (qa[0].addr == qb[0].addr || m_lg_a) gb = 1;
            else ga = 1;
        end else begin
            ga = (qa.size() != 0);
            gb = (qb.size() != 0);
        end
    endfunction

    function automatic bit exp_a_ready();
        bit ga, gb;
        model_grant(ga, gb);
        return (qa.size() == 0) || ga;
    endfunction

    function automatic bit exp_b_ready();
        bit ga, gb;
        model_grant(ga, gb);
        return (qb.size() == 0) || gb;
    endfunction

    function automatic void model_clear();
        qa.delete();
        qb.delete();
        m_lg_a  = 0;
        m_we    = 0;
        m_sel   = 0;
        m_waddr = '0;
        m_wdata = '0;
        m_conf  = 0;
    endfunction

    // Advance model and DUT by one edge using the currently driven inputs;
    // returns at posedge + 1.
    task automatic tick();
        bit ga, gb, ra, rb;
        ent_t e;
        model_grant(ga, gb);
        ra = (qa.size() == 0) || ga;
        rb = (qb.size() == 0) || gb;
        if (qa.size() != 0 && qb.size() != 0 && m_conf < CMAX) m_conf++;
        m_we = 0;
        if (ga) begin
            e = qa.pop_front();
            m_lg_a = 1; m_sel = 1; m_we = (e.addr != 0);
            m_waddr = e.addr; m_wdata = e.data;
        end else if (gb) begin
            e = qb.pop_front();
            m_lg_a = 0; m_sel = 0; m_we = (e.addr != 0);
            m_waddr = e.addr; m_wdata = e.data;
        end
        if (a_valid && ra) qa.push_back('{a_addr, a_data});
        if (b_valid && rb) qb.push_back('{b_addr, b_data});
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 0;
        model_clear();
        #12;
        checks++;
        if ({we, sel, waddr, wdata, conflicts} !== '0) begin
            errs++; $display("FAIL reset_outputs: got we=%b sel=%b waddr=%0d wdata=%h conf=%0d want all 0",
                             we, sel, waddr, wdata, conflicts);
        end
        checks++;
        if ({a_ready, b_ready} !== 2'b11) begin
            errs++; $display("FAIL reset_ready: got %b%b want 11", a_ready, b_ready);
        end
        do_reset();
    endtask

    task automatic test_single_a();
        do_reset();
        drive(1, 5, 32'h1111_2222, 0, 0, 0);
        checks++;
        if (a_ready !== 1'b1) begin errs++; $display("FAIL single_ready: got %b want 1", a_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if ({we, sel, waddr, wdata} !== {1'b1, 1'b1, 5'd5, 32'h1111_2222}) begin
            errs++; $display("FAIL single_write: got we=%b sel=%b waddr=%0d wdata=%h want 1 1 5 11112222",
                             we, sel, waddr, wdata);
        end
        tick();
        checks++;
        if (we !== 1'b0) begin errs++; $display("FAIL single_we_drop: got %b want 0", we); end
    endtask

    task automatic test_diff_addr();
        do_reset();
        drive(1, 3, 32'hA3, 1, 7, 32'hB7);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errs++; $display("FAIL diff_ready: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
        end
        tick();
        checks++;
        if ({we, sel, waddr, wdata} !== {1'b1, 1'b1, 5'd3, 32'hA3}) begin
            errs++; $display("FAIL diff_first: got we=%b sel=%b waddr=%0d wdata=%h want 1 1 3 a3",
                             we, sel, waddr, wdata);
        end
        tick();
        checks++;
        if ({we, sel, waddr, wdata} !== {1'b1, 1'b0, 5'd7, 32'hB7}) begin
            errs++; $display("FAIL diff_second: got we=%b sel=%b waddr=%0d wdata=%h want 1 0 7 b7",
                             we, sel, waddr, wdata);
        end
        checks++;
        if (conflicts !== 4'd1) begin errs++; $display("FAIL diff_conflicts: got %0d want 1", conflicts); end
    endtask

    task automatic test_same_addr();
        do_reset();
        drive(1, 1, 32'h0101, 0, 0, 0);   // leave lg pointing at A
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 9, 32'hAAAA_0009, 1, 9, 32'hBBBB_0009);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if ({we, sel, waddr, wdata} !== {1'b1, 1'b0, 5'd9, 32'hBBBB_0009}) begin
            errs++; $display("FAIL same_first_b: got we=%b sel=%b waddr=%0d wdata=%h want 1 0 9 bbbb0009",
                             we, sel, waddr, wdata);
        end
        tick();
        checks++;
        if ({we, sel, waddr, wdata} !== {1'b1, 1'b1, 5'd9, 32'hAAAA_0009}) begin
            errs++; $display("FAIL same_then_a: got we=%b sel=%b waddr=%0d wdata=%h want 1 1 9 aaaa0009",
                             we, sel, waddr, wdata);
        end
        tick();
        checks++;
        if (dut_rf[9] !== 32'hAAAA_0009) begin
            errs++; $display("FAIL same_final_rf: got %h want aaaa0009", dut_rf[9]);
        end
        checks++;
        if (conflicts !== 4'd1) begin errs++; $display("FAIL same_conflicts: got %0d want 1", conflicts); end
    endtask

    task automatic test_reg_zero();
        // Runs after a sel=1/waddr=9 write so the port must visibly move.
        drive(0, 0, 0, 1, 0, 32'hFFFF_FFFF);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if ({we, sel, waddr} !== {1'b0, 1'b0, 5'd0}) begin
            errs++; $display("FAIL zero_write: got we=%b sel=%b waddr=%0d want 0 0 0", we, sel, waddr);
        end
        checks++;
        if (b_ready !== 1'b1) begin errs++; $display("FAIL zero_consumed: got b_ready=%b want 1", b_ready); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 8; i++) begin
            drive(i < 8, AW'(10 + i), 32'h5000 + i, 0, 0, 0);
            if (i < 8) begin
                checks++;
                if (a_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, a_ready); end
            end
            tick();
            if (i >= 1) begin
                checks++;
                if ({we, sel, waddr, wdata} !== {1'b1, 1'b1, AW'(9 + i), 32'h5000 + i - 1}) begin
                    errs++; $display("FAIL b2b_write[%0d]: got we=%b sel=%b waddr=%0d wdata=%h want 1 1 %0d %h",
                                     i, we, sel, waddr, wdata, 9 + i, 32'h5000 + i - 1);
                end
            end
        end
        tick();
        checks++;
        if (we !== 1'b0) begin errs++; $display("FAIL b2b_end: got we=%b want 0", we); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < CMAX + 6; i++) begin
            drive(1, 1, $urandom, 1, 2, $urandom);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (conflicts !== CW'(CMAX)) begin
            errs++; $display("FAIL sat_conflicts: got %0d want %0d", conflicts, CMAX);
        end
        repeat (3) tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), AW'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 1), AW'($urandom_range(0, 3)), $urandom);
            checks++;
            if ({a_ready, b_ready} !== {exp_a_ready(), exp_b_ready()}) begin
                errs++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", i, a_ready, b_ready,
                                 exp_a_ready(), exp_b_ready());
            end
            tick();
            checks++;
            if (we !== m_we || sel !== m_sel || waddr !== m_waddr || conflicts !== CW'(m_conf) ||
                (m_we && wdata !== m_wdata)) begin
                errs++; $display("FAIL rnd_port[%0d]: got we=%b sel=%b waddr=%0d wdata=%h conf=%0d want %b %b %0d %h %0d",
                                 i, we, sel, waddr, wdata, conflicts, m_we, m_sel, m_waddr, m_wdata, m_conf);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 4, 32'h44, 1, 5, 32'h55);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 0;
        model_clear();
        #1;
        checks++;
        if ({we, sel, waddr, wdata, conflicts} !== '0 || {a_ready, b_ready} !== 2'b11) begin
            errs++; $display("FAIL midrst_async: got we=%b sel=%b waddr=%0d wdata=%h conf=%0d rdy=%b%b want zeros rdy=11",
                             we, sel, waddr, wdata, conflicts, a_ready, b_ready);
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (we !== 1'b0 || {a_ready, b_ready} !== 2'b11) begin
                errs++; $display("FAIL midrst_no_write[%0d]: got we=%b rdy=%b%b want 0 11", i, we, a_ready, b_ready);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) dut_rf[i] = '0;
        rst_n = 0;
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_single_a();
        test_diff_addr();
        test_same_addr();
        test_reg_zero();
        test_back_to_back();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Arbitrates two writeback requesters, A (ALU result) and B (memory/load result), onto the single register-file write port. Each side has a one-entry holding buffer. The block drives the select of the 5-bit destination-address 2:1 mux (sel=1 selects A, sel=0 selects B) and the registered write-port signals. It sits between the EX/MEM writeback paths and the register file.

Parameters:
AW, 5, register address width
DW, 32, write-data width
CW, 16, conflict counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
a_valid  input  1  requester A has a write
a_addr  input  AW  A destination register
a_data  input  DW  A write data
a_ready  output  1  A transfer accepted when a_valid & a_ready
b_valid  input  1  requester B has a write
b_addr  input  AW  B destination register
b_data  input  DW  B write data
b_ready  output  1  B transfer accepted when b_valid & b_ready
sel  output  1  address mux select, registered; 1 = A, 0 = B
we  output  1  register-file write enable, registered
waddr  output  AW  register-file write address, registered
wdata  output  DW  register-file write data, registered
conflicts  output  CW  saturating count of cycles in which both buffers were full

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: sel=0, we=0, waddr=0, wdata=0, conflicts=0, both buffers empty, last-grant pointer lg=B.
- Reset asserted mid-operation: buffered writes are discarded and no partial write is issued.
- Buffers: buf_a and buf_b each hold one entry {full, addr, data}. A transfer loads its buffer at the clock edge.
- Ready: x_ready = !full_x | grant_x, which allows back-to-back acceptance while draining. When grant_x and x_valid are both true in the same cycle, the buffer unloads and reloads at one edge.
- Grant, combinational on buffer state each cycle:
  - Only one buffer full: grant it.
  - Both full, addresses differ: round-robin; grant the side not equal to lg.
  - Both full, addresses equal: grant B first regardless of lg, preserving program order (load is older). A is granted next cycle.
  - Neither full: no grant.
- lg updates to the granted side on every grant.
- Write port (registered, updates at the edge after the grant):
  - we=1 and waddr/wdata = granted entry.
  - sel=1 if A was granted, 0 if B.
  - No grant: we=0; sel, waddr and wdata hold their previous values.
- Register zero: an entry with addr=0 is granted and consumed normally, but we=0 for that cycle. waddr and sel still update.
- Latency: input transfer at edge N, grant in cycle N, we asserted after edge N+1. Uncontended latency is 2 edges; throughput is one write per cycle.
- Conflict counter: increments by 1 on each edge where both buffers were full, saturating at 2^CW-1.
- Simultaneous events: acceptance and grant on the same side in one cycle is legal (see Ready). The non-granted full side holds its entry and deasserts ready.

Test Plan:
1. Reset, then A alone writes addr=5, data=0x1111_2222 -> two edges later we=1, waddr=5, wdata=0x11112222, sel=1; next cycle we=0.
2. A and B load simultaneously with addr 3 and addr 7 (lg=B) -> grant A first (sel=1, waddr=3), then B (sel=0, waddr=7); conflicts=1; a_ready=1 and b_ready=0 during the first grant cycle.
3. Both full with addr=9, lg=A -> B written first, then A; final register value is A's data; conflicts=1.
4. B writes addr=0, data=0xFFFF_FFFF -> b consumed, we stays 0, waddr=0, sel=0.
5. A streams 8 back-to-back writes with a_valid held high -> a_ready stays 1 and we=1 for 8 consecutive cycles with addresses in order.
6. Assert rst_n low while both buffers are full -> all outputs return to reset values immediately (async), no write is issued after release, and a_ready=b_ready=1.
